// File: rtl/hier_node_rr_aggregator_if.sv
// rtl/hier_node_rr_aggregator_if.sv - child fan-in and parent-facing stream bundle for the aggregator node
interface hier_node_rr_aggregator_if #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_CHILD)
);
    logic [NUM_CHILD-1:0]        child_valid;
    logic [NUM_CHILD*DATA_W-1:0] child_data;
    logic [NUM_CHILD-1:0]        child_ready;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_ready;

    // The node itself: consumes child traffic, produces the parent stream.
    modport slave (
        input  child_valid,
        input  child_data,
        input  out_ready,
        output child_ready,
        output out_valid,
        output out_data,
        output out_idx
    );

    // Whatever drives the node: the children plus the parent's ready.
    modport master (
        output child_valid,
        output child_data,
        output out_ready,
        input  child_ready,
        input  out_valid,
        input  out_data,
        input  out_idx
    );
endinterface

// File: rtl/hier_node_rr_aggregator.sv
// rtl/hier_node_rr_aggregator.sv - round-robin child fan-in with index-tagged FWFT output FIFO
module hier_node_rr_aggregator #(
    parameter int  NUM_CHILD  = 5,
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(NUM_CHILD),
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hier_node_rr_aggregator_if.slave bus,
    output logic [LVL_W-1:0]        fifo_level_o,
    output logic [15:0]             xfer_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = IDX_W + DATA_W;

    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]          xfer_cnt_q, xfer_cnt_d;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_W-1:0]    grant_data;
    logic [NUM_CHILD-1:0] child_ready;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 out_valid;
    logic [ENT_W-1:0]     head;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CHILD) s = s - NUM_CHILD;
        return IDX_W'(s);
    endfunction

    // First requesting child at or after rr_ptr, scanning with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            if (!grant_found && bus.child_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    assign grant_data = bus.child_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign out_valid  = (level_q != '0);

    // Full blocks the push even if the head pops this cycle.
    assign push = rst_n && grant_found && !full;
    assign pop  = out_valid && bus.out_ready;

    always_comb begin
        child_ready = '0;
        if (push) child_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rr_ptr_d   = rr_ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rr_ptr_d = (grant_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : grant_idx + IDX_W'(1);
            if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rr_ptr_q   <= '0;
            xfer_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Storage needs no reset: nothing is visible until level says so.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {grant_idx, grant_data};
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.child_ready = child_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? head[DATA_W-1:0] : '0;
    assign bus.out_idx     = out_valid ? head[ENT_W-1:DATA_W] : '0;
    assign fifo_level_o    = level_q;
    assign xfer_cnt_o      = xfer_cnt_q;
endmodule

// File: tb/tb_hier_node_rr_aggregator.sv
// tb/tb_hier_node_rr_aggregator.sv - directed and scoreboard checks for hier_node_rr_aggregator
module tb_hier_node_rr_aggregator;
    localparam int NUM_CHILD = 5;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  fifo_level;
    logic [15:0] xfer_cnt;
    int          total = 0;
    int          bad   = 0;

    hier_node_rr_aggregator_if #(.NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W)) bus ();

    hier_node_rr_aggregator #(.NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .fifo_level_o (fifo_level),
        .xfer_cnt_o   (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < NUM_CHILD; i++) bus.child_data[i*DATA_W +: DATA_W] = 32'hA0 + i;
    endtask

    task automatic do_reset();
        bus.child_valid = '0;
        bus.out_ready   = 1'b0;
        set_default_data();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.child_valid = '1;
        bus.out_ready   = 1'b0;
        set_default_data();
        rst_n = 1'b0;
        tick();
        total++; if (bus.child_ready !== 5'b0) begin bad++; $display("FAIL rst_ready got=%b want=%b", bus.child_ready, 5'b0); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
        total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", xfer_cnt); end
        total++; if (bus.out_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.out_data); end
        rst_n = 1'b1;
        bus.child_valid = 5'b00100;
        repeat (3) tick();
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL pre_level got=%0d want=3", fifo_level); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.out_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
        total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", xfer_cnt); end
        total++; if (bus.child_ready !== 5'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", bus.child_ready); end
        tick();
        rst_n = 1'b1;
        bus.child_valid = '1;
        #1;
        total++; if (bus.child_ready !== 5'b00001) begin bad++; $display("FAIL post_rst_grant got=%b want=00001", bus.child_ready); end
        tick();
        total++; if (bus.out_idx !== 3'd0 || bus.out_data !== 32'hA0) begin bad++; $display("FAIL post_rst_head got=%0d/%h want=0/a0", bus.out_idx, bus.out_data); end
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        bus.child_valid = '1;
        bus.out_ready   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            e = k % NUM_CHILD;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid k=%0d got=%b want=1", k, bus.out_valid); end
            total++; if (bus.out_idx !== 3'(e)) begin bad++; $display("FAIL rr_idx k=%0d got=%0d want=%0d", k, bus.out_idx, e); end
            total++; if (bus.out_data !== 32'hA0 + e) begin bad++; $display("FAIL rr_data k=%0d got=%h want=%h", k, bus.out_data, 32'hA0 + e); end
        end
        total++; if (xfer_cnt !== 16'd10) begin bad++; $display("FAIL rr_cnt got=%0d want=10", xfer_cnt); end
        bus.child_valid = '0;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) begin bad++; $display("FAIL rr_drain got=%b/%h want=0/0", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_wrap_skip();
        int exp_idx [4] = '{1, 4, 1, 4};
        do_reset();
        bus.child_valid = 5'b00010;
        tick();
        bus.child_valid = 5'b10010;
        #1;
        total++; if (bus.child_ready !== 5'b10000) begin bad++; $display("FAIL ws_g0 got=%b want=10000", bus.child_ready); end
        tick();
        total++; if (bus.child_ready !== 5'b00010) begin bad++; $display("FAIL ws_g1 got=%b want=00010", bus.child_ready); end
        tick();
        total++; if (bus.child_ready !== 5'b10000) begin bad++; $display("FAIL ws_g2 got=%b want=10000", bus.child_ready); end
        tick();
        bus.child_valid = '0;
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ws_level got=%0d want=4", fifo_level); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.out_idx !== 3'(exp_idx[k]) || bus.out_data !== 32'hA0 + exp_idx[k]) begin
                bad++; $display("FAIL ws_pop k=%0d got=%0d/%h want=%0d/%h", k, bus.out_idx, bus.out_data, exp_idx[k], 32'hA0 + exp_idx[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.child_valid = '1;
        repeat (4) tick();
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_full got=%0d want=4", fifo_level); end
        total++; if (bus.child_ready !== 5'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", bus.child_ready); end
        total++; if (bus.out_idx !== 3'd0) begin bad++; $display("FAIL bp_head got=%0d want=0", bus.out_idx); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL bp_pop_level got=%0d want=3", fifo_level); end
        total++; if (xfer_cnt !== 16'd4) begin bad++; $display("FAIL bp_nopush got=%0d want=4", xfer_cnt); end
        total++; if (bus.out_idx !== 3'd1) begin bad++; $display("FAIL bp_head2 got=%0d want=1", bus.out_idx); end
        total++; if (bus.child_ready !== 5'b10000) begin bad++; $display("FAIL bp_resume got=%b want=10000", bus.child_ready); end
        tick();
        total++; if (fifo_level !== 3'd4 || xfer_cnt !== 16'd5) begin bad++; $display("FAIL bp_refill got=%0d/%0d want=4/5", fifo_level, xfer_cnt); end
    endtask

    task automatic test_concurrent();
        int          q_idx [$];
        logic [31:0] q_dat [$];
        logic [31:0] dat [NUM_CHILD];
        logic [4:0]  cv;
        logic [4:0]  exp_ready;
        logic        ordy;
        bit          found, push_m, pop_m;
        int          rr, g;
        do_reset();
        rr = 0;
        for (int it = 0; it < 23; it++) begin
            if (it == 0)      begin cv = 5'b00001; ordy = 1'b0; end
            else if (it == 1) begin cv = 5'b00100; ordy = 1'b0; end
            else if (it == 2) begin cv = 5'b01000; ordy = 1'b1; end
            else begin cv = 5'($urandom_range(0, 31)); ordy = 1'($urandom_range(0, 1)); end
            for (int i = 0; i < NUM_CHILD; i++) begin
                dat[i] = $urandom;
                bus.child_data[i*DATA_W +: DATA_W] = dat[i];
            end
            bus.child_valid = cv;
            bus.out_ready   = ordy;
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_CHILD; k++) begin
                if (!found && cv[(rr + k) % NUM_CHILD]) begin found = 1'b1; g = (rr + k) % NUM_CHILD; end
            end
            push_m    = found && (q_idx.size() < 4);
            pop_m     = (q_idx.size() != 0) && ordy;
            exp_ready = push_m ? 5'(1 << g) : 5'b0;
            #1;
            total++; if (bus.child_ready !== exp_ready) begin bad++; $display("FAIL cc_ready it=%0d got=%b want=%b", it, bus.child_ready, exp_ready); end
            total++; if (fifo_level !== 3'(q_idx.size())) begin bad++; $display("FAIL cc_level it=%0d got=%0d want=%0d", it, fifo_level, q_idx.size()); end
            if (q_idx.size() != 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(q_idx[0]) || bus.out_data !== q_dat[0]) begin
                    bad++; $display("FAIL cc_head it=%0d got=%b/%0d/%h want=1/%0d/%h", it, bus.out_valid, bus.out_idx, bus.out_data, q_idx[0], q_dat[0]);
                end
            end else begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL cc_empty it=%0d got=%b want=0", it, bus.out_valid); end
            end
            tick();
            if (pop_m) begin void'(q_idx.pop_front()); void'(q_dat.pop_front()); end
            if (push_m) begin
                q_idx.push_back(g);
                q_dat.push_back(dat[g]);
                rr = (g + 1) % NUM_CHILD;
            end
            if (it == 2) begin
                total++; if (fifo_level !== 3'd2 || bus.out_idx !== 3'd2) begin bad++; $display("FAIL cc_pushpop got=%0d/%0d want=2/2", fifo_level, bus.out_idx); end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.child_valid = '1;
        bus.out_ready   = 1'b1;
        repeat (65534) tick();
        total++; if (xfer_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", xfer_cnt); end
        tick();
        total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=ffff", xfer_cnt); end
        repeat (2) tick();
        total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", xfer_cnt); end
        bus.child_valid = '0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_wrap_skip();
        test_backpressure();
        test_concurrent();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
